// File: rtl/dbus_pkg.sv
// rtl/dbus_pkg.sv - shared size codes, FSM states and address constants for the data-bus master
package dbus_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
  localparam logic [31:0] EXIT_ADDR   = 32'hFF00_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } dbus_state_t;

  // Size code 11 behaves as a byte, so it is never misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_WORD: return addr_lo != 2'b00;
      SZ_HALF: return addr_lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbus_lane_fmt.sv
// rtl/dbus_lane_fmt.sv - store data masking and load sign/zero extension
module dbus_lane_fmt
  import dbus_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [BIT_WIDTH-1:0] wdata,
  input  logic [BIT_WIDTH-1:0] bus_rdata,
  output logic [BIT_WIDTH-1:0] bus_wdata,
  output logic [BIT_WIDTH-1:0] rdata_ext
);

  always_comb begin
    bus_wdata = wdata;
    rdata_ext = bus_rdata;
    case (size)
      SZ_WORD: begin
        bus_wdata = wdata;
        rdata_ext = bus_rdata;
      end
      SZ_HALF: begin
        bus_wdata = {{(BIT_WIDTH-16){1'b0}}, wdata[15:0]};
        rdata_ext = {{(BIT_WIDTH-16){sign_ext & bus_rdata[15]}}, bus_rdata[15:0]};
      end
      default: begin
        bus_wdata = {{(BIT_WIDTH-8){1'b0}}, wdata[7:0]};
        rdata_ext = {{(BIT_WIDTH-8){sign_ext & bus_rdata[7]}}, bus_rdata[7:0]};
      end
    endcase
  end

endmodule

// File: rtl/dbus_master.sv
// rtl/dbus_master.sv - single-outstanding load/store initiator for the external data-memory bus
module dbus_master
  import dbus_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);

  dbus_state_t          state;
  logic [7:0]           wait_cnt;
  logic                 sign_q;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic [BIT_WIDTH-1:0] bus_wdata;
  logic [BIT_WIDTH-1:0] rdata_ext;
  logic [7:0]           wait_next;

  dbus_lane_fmt #(.BIT_WIDTH(BIT_WIDTH)) u_lane_fmt (
    .size      (SIZE),
    .sign_ext  (sign_q),
    .wdata     (wdata_q),
    .bus_rdata (DDT),
    .bus_wdata (bus_wdata),
    .rdata_ext (rdata_ext)
  );

  // Enable comes straight from registers so an async reset releases the bus at once.
  assign DDT       = (MREQ && WRITE) ? bus_wdata : {BIT_WIDTH{1'bz}};
  assign wait_next = wait_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= 8'd0;
      sign_q     <= 1'b0;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      DAD        <= '0;
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= SZ_WORD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state    <= ST_BUS;
              DAD      <= req_addr;
              SIZE     <= req_size;
              WRITE    <= req_write;
              sign_q   <= req_signed;
              wdata_q  <= req_wdata;
              MREQ     <= 1'b1;
              wait_cnt <= 8'd0;
            end
          end
        end
        ST_BUS: begin
          // ACK is checked first so it beats a timeout on the same edge.
          if (!ACKD_n) begin
            state      <= ST_RESP;
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= WRITE ? '0 : rdata_ext;
          end else begin
            wait_cnt <= wait_next;
            if (wait_next == 8'(TIMEOUT)) begin
              state      <= ST_RESP;
              MREQ       <= 1'b0;
              WRITE      <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          wait_cnt   <= 8'd0;
        end
        default: begin
          state     <= ST_IDLE;
          MREQ      <= 1'b0;
          WRITE     <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_master.sv
// tb/tb_dbus_master.sv - randomized self-checking bench for dbus_master against a behavioural model
module tb_dbus_master;
  import dbus_pkg::*;

  localparam int TO = 4;
  localparam logic [31:0] PROBE = 32'h0F0F_0F00;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, DAD;
  logic        MREQ, WRITE;
  logic [1:0]  SIZE;
  wire  [31:0] DDT;
  logic        ACKD_n;
  logic [31:0] mem_rdata;
  logic        probe_en;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory drives read data during load cycles; the probe is used to see that the DUT has released DDT.
  assign DDT = probe_en ? PROBE : ((MREQ && !WRITE) ? mem_rdata : 32'bz);

  dbus_master #(.BIT_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .DDT(DDT), .ACKD_n(ACKD_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] addr);
    if (sz == 2'b00) return (addr % 4) != 0;
    if (sz == 2'b01) return (addr % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_store(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return d;
    if (sz == 2'b01) return d % 32'd65536;
    return d % 32'd256;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sg, input logic [31:0] d);
    longint v;
    if (sz == 2'b00) return d;
    if (sz == 2'b01) begin
      v = longint'(d % 32'd65536);
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(d % 32'd256);
      if (sg && v >= 128) v = v - 256;
    end
    return v[31:0];
  endfunction

  task automatic check_released(input string tag);
    probe_en = 1'b1;
    #1;
    check(tag, DDT, PROBE);
    probe_en = 1'b0;
  endtask

  // waits: number of wait states before ACK; negative means ACK never comes.
  task automatic run_access(input bit wr, input logic [1:0] sz, input bit sg, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] mem, input int waits);
    int          n;
    int          exp_n;
    bit          acked;
    logic [31:0] exp_rd;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    mem_rdata  = mem;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (ref_misaligned(sz, addr)) begin
      check("mis_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("mis_resp_err", {31'd0, resp_err}, 32'd1);
      check("mis_rdata", resp_rdata, 32'd0);
      check("mis_mreq", {31'd0, MREQ}, 32'd0);
      exp_rd = 32'd0;
    end else begin
      acked = (waits >= 0) && (waits < TO);
      exp_n = acked ? waits + 1 : TO;
      n = 0;
      while (!resp_valid && n <= TO + 2) begin
        check("bus_mreq", {31'd0, MREQ}, 32'd1);
        check("bus_dad", DAD, addr);
        check("bus_write", {31'd0, WRITE}, {31'd0, wr});
        check("bus_size", {30'd0, SIZE}, {30'd0, sz});
        if (wr) check("bus_ddt", DDT, ref_store(sz, wd));
        ACKD_n = (waits == n) ? 1'b0 : 1'b1;
        @(posedge clk);
        #1 ACKD_n = 1'b1;
        n++;
      end
      exp_rd = (wr || !acked) ? 32'd0 : ref_load(sz, sg, mem);
      check("bus_cycles", 32'(n), 32'(exp_n));
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_err", {31'd0, resp_err}, {31'd0, !acked});
      check("resp_rdata", resp_rdata, exp_rd);
      check("resp_mreq", {31'd0, MREQ}, 32'd0);
    end
    check_released("ddt_released");
    @(posedge clk);
    #1;
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);
    check("rdata_hold", resp_rdata, exp_rd);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; ACKD_n = 1'b1; mem_rdata = '0; probe_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mreq", {31'd0, MREQ}, 32'd0);
    check("rst_write", {31'd0, WRITE}, 32'd0);
    check("rst_size", {30'd0, SIZE}, 32'd0);
    check("rst_dad", DAD, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check_released("rst_ddt");

    run_access(1'b0, SZ_WORD, 1'b0, 32'h0800_0010, 32'd0, 32'h1234_ABCD, 0);
    run_access(1'b0, SZ_BYTE, 1'b1, 32'h0800_0021, 32'd0, 32'h0000_0080, 0);
    run_access(1'b0, SZ_BYTE, 1'b0, 32'h0800_0021, 32'd0, 32'h0000_0080, 1);
    run_access(1'b0, SZ_HALF, 1'b1, 32'h0800_0022, 32'd0, 32'h0000_8001, 2);
    run_access(1'b1, SZ_BYTE, 1'b0, STDOUT_ADDR, 32'hDEAD_BE41, 32'd0, 3);
    run_access(1'b1, SZ_WORD, 1'b0, EXIT_ADDR, 32'h0000_0001, 32'd0, 0);
    run_access(1'b0, SZ_HALF, 1'b0, 32'h0800_0003, 32'd0, 32'h5555_5555, 0);
    run_access(1'b0, SZ_WORD, 1'b0, 32'h0800_0002, 32'd0, 32'h5555_5555, 0);
    run_access(1'b0, SZ_WORD, 1'b0, 32'h0800_0040, 32'd0, 32'hCAFE_F00D, -1);
    run_access(1'b0, SZ_WORD, 1'b0, 32'h0800_0040, 32'd0, 32'hCAFE_F00D, TO - 1);

    // Async reset in the 2nd BUS cycle of a store aborts it with no response.
    @(negedge clk);
    req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h0800_0100; req_wdata = 32'hA5A5_0001; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("abort_mreq_before", {31'd0, MREQ}, 32'd1);
    #2 rst = 1'b1;
    #1 check("abort_mreq", {31'd0, MREQ}, 32'd0);
    check_released("abort_ddt");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_access(1'b0, SZ_WORD, 1'b0, 32'h0800_0104, 32'd0, 32'h0BAD_BEEF, 1);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = $urandom;
      if (($urandom % 4) != 0) a = a & 32'hFFFF_FFFC;
      run_access(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), a,
                 $urandom, $urandom, int'($urandom_range(0, 6)) - 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_master.md
# dbus_master

Processor-side initiator for the external data-memory bus. Accepts one load or store at a time from the MEM pipeline stage and drives DAD/MREQ/WRITE/SIZE/DDT. Waits for ACKD_n, then returns sign- or zero-extended load data and stalls the pipeline while a transfer is outstanding. It sits inside `top` between the MEM stage and the chip-level data-bus pins.

## Interface
Parameters:
- BIT_WIDTH, 32, address/data width
- TIMEOUT, 255, maximum cycles to wait for ACKD_n before aborting (8-bit counter)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  MEM stage presents an access
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 halfword, 10 byte (11 treated as byte)
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  BIT_WIDTH  byte address
- req_wdata  in  BIT_WIDTH  store data, right-aligned
- req_ready  out  1  block is IDLE and can accept; pipeline stall = req_valid & ~req_ready
- resp_valid  out  1  one-cycle pulse when an access completes
- resp_rdata  out  BIT_WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned access or timeout
- DAD  out  BIT_WIDTH  bus address
- MREQ  out  1  bus request, active-high
- WRITE  out  1  1 = store cycle
- SIZE  out  2  bus size code, same encoding as req_size
- DDT  inout  BIT_WIDTH  bus data; driven only while MREQ & WRITE, otherwise high-Z
- ACKD_n  in  1  memory acknowledge, active-low

## Operation
- States are IDLE, BUS, RESP.
- **IDLE**
  - req_ready=1.
  - If req_valid and the request is aligned, latch addr/size/write/signed/wdata and go to BUS.
  - If req_valid and the request is misaligned, go to RESP with err=1 and issue no bus cycle. Misaligned means word with addr[1:0]≠0, or halfword with addr[0]=1.
- **BUS**
  - MREQ=1; DAD, WRITE and SIZE come from the latched values.
  - Store: DDT carries the latched wdata masked to the size (byte in [7:0], half in [15:0], upper bits 0).
  - On the edge where ACKD_n=0: for loads, capture DDT into the read-data register; go to RESP.
  - The wait counter increments on each BUS cycle with ACKD_n=1. If it reaches TIMEOUT, go to RESP with err=1.
- **RESP**
  - resp_valid=1 for exactly one cycle, MREQ=0, DDT released; return to IDLE.
- **Load extension**
  - Word: DDT passed through.
  - Half: bit 15 replicated or zero-filled into [31:16].
  - Byte: bit 7 replicated or zero-filled into [31:8].
- ACKD_n low while in IDLE or RESP is ignored.
- No address decoding: STDOUT (0xF000_0000) and EXIT (0xFF00_0000) stores are ordinary byte/word stores.

## Timing
- Reset values: MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT high-Z, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, counter=0, state IDLE.
- Asserting rst mid-transfer drops MREQ and releases DDT immediately. No response is issued for the aborted access.
- Bus outputs are registered. MREQ rises the cycle after acceptance and falls the cycle after the ACK edge.
- Latency from accept to resp_valid is N+1 cycles, where N is the number of BUS cycles (N=1 for zero wait states). Minimum occupancy is 3 cycles per access (IDLE, BUS, RESP).
- Misaligned access: resp_valid with err=1 on the cycle after acceptance; MREQ never rises.
- Timeout: MREQ stays high for exactly TIMEOUT cycles; resp_err=1 on the following cycle.
- ACKD_n low on the same edge the counter hits TIMEOUT: the ACK wins and err=0.
- resp_rdata holds its value until the next resp_valid.

## Structure
- Shared package `dbus_pkg` holds:
  - SIZE codes (SZ_WORD=00, SZ_HALF=01, SZ_BYTE=10)
  - state encoding (IDLE/BUS/RESP)
  - STDOUT_ADDR and EXIT_ADDR constants
- One combinational sub-module `dbus_lane_fmt` handles store masking and load extension. Its inputs are size, signed, wdata and bus data; its outputs are bus write data and the extended read data.
- The FSM, counter and bus registers stay in dbus_master.

## Test plan
- Load word, addr 0x0800_0010, memory returns 0x1234_ABCD with zero wait states → MREQ high 1 cycle, WRITE=0, SIZE=00; resp_rdata=0x1234_ABCD, resp_err=0, latency 2.
- Signed byte load, DDT=0x0000_0080 → resp_rdata=0xFFFF_FF80; the same access unsigned → 0x0000_0080. Signed half with DDT=0x0000_8001 → 0xFFFF_8001.
- Store byte, addr 0xF000_0000, wdata 0xDEAD_BE41 with 3 wait states → DDT=0x0000_0041, SIZE=10, WRITE=1 for 4 BUS cycles; resp_valid once; DDT high-Z afterwards.
- Halfword load at 0x0800_0003 → resp_valid+resp_err the next cycle, MREQ never asserted. Word at 0x0800_0002 → same result.
- ACKD_n held high, TIMEOUT=4 → MREQ high exactly 4 cycles, then resp_err=1. Repeat with ACK arriving on the 4th cycle → resp_err=0.
- rst pulsed during the 2nd BUS cycle of a store → MREQ=0 and DDT high-Z immediately, no resp_valid; next request proceeds normally.
